pll_reset_supervisor: RTL and testbench
=======================================

// Module: pll_reset_supervisor
// PURPOSE
//   Parametrised PLL lock supervisor and reset sequencer for the GPU clocking subsystem.
//   Runs on the 50 MHz board reference. It drives the PLL reset, qualifies the raw lock
//   signal, then releases NUM_DOMAINS domain resets in staggered order (SRAM, pixel, TMDS, ...).
//   It detects lock loss, retries on lock timeout and counts relock events.
//   Each domain_rst bit is re-synchronised inside its own clock domain by the consumer.
// PARAMETERS
//   NUM_DOMAINS          3      number of downstream domain reset outputs (>=1)
//   PLL_RST_CYCLES       32     cycles pll_rst is held high per reset attempt (>=1)
//   LOCK_STABLE_CYCLES   1024   consecutive synced-lock-high cycles required before release (>=1)
//   LOCK_TIMEOUT_CYCLES  50000  max cycles in WAIT_LOCK before a PLL retry (1 ms at 50 MHz)
//   RELEASE_STAGGER      16     cycles between successive domain reset releases (>=1)
//   CNT_W                8      width of relock_count
// PORTS
//   clk_50_in      in   1            50 MHz reference clock
//   rst            in   1            async active-high reset
//   pll_lock_raw   in   1            PLL LOCK, asynchronous to clk_50_in
//   sw_reset_req   in   1            single-cycle request for a full PLL re-initialisation
//   pll_rst        out  1            reset to the PLL primitive, active-high
//   domain_rst     out  NUM_DOMAINS  per-domain reset, active-high; bit 0 is released first
//   all_ready      out  1            high only in RUN: all domains released
//   relock_count   out  CNT_W        saturating count of lock-loss events after the first release
//   timeout_flag   out  1            sticky; set on any WAIT_LOCK timeout; cleared only by rst
// BEHAVIOUR
//   Reset values (async, while rst=1):
//     state=PLL_RESET, pll_rst=1, domain_rst=all 1, all_ready=0, relock_count=0, timeout_flag=0.
//   Lock sync: pll_lock_raw passes through a 2-flop synchroniser to give lock_s (2-cycle latency).
//     Only lock_s is used internally.
//   All outputs are registered. A single cycle counter, sized by $clog2 of the largest
//     parameter, is cleared on every state entry.
//   States:
//   PLL_RESET : pll_rst=1 for exactly PLL_RST_CYCLES cycles, counted from the first edge after
//               entry. Then go to WAIT_LOCK.
//   WAIT_LOCK : pll_rst=0. If lock_s=1, go to STABLE.
//               Else, after LOCK_TIMEOUT_CYCLES cycles: set timeout_flag and go to PLL_RESET.
//               If lock_s rises on the timeout cycle, lock wins and the next state is STABLE.
//   STABLE    : counts consecutive lock_s=1 cycles. On reaching LOCK_STABLE_CYCLES, go to RELEASE.
//               Any lock_s=0 sends the block to WAIT_LOCK with a fresh timeout. No count increment.
//   RELEASE   : domain_rst[0] clears on the first RELEASE cycle.
//               domain_rst[i] clears i*RELEASE_STAGGER cycles after domain_rst[0].
//               The cycle after domain_rst[NUM_DOMAINS-1] clears, go to RUN.
//   RUN       : all_ready=1, domain_rst=all 0.
//   Lock loss in RELEASE or RUN (lock_s=0):
//     - next edge: domain_rst=all 1, all_ready=0.
//     - relock_count increments, saturating at 2^CNT_W-1.
//     - go to WAIT_LOCK.
//   sw_reset_req=1 in any state except PLL_RESET:
//     - next edge: domain_rst=all 1, all_ready=0, go to PLL_RESET.
//     - relock_count is unchanged.
//     - it takes priority over a simultaneous lock loss; that cycle does not increment the count.
//   sw_reset_req in PLL_RESET is ignored; the attempt is not restarted.
//   domain_rst is all 1 in every state except RELEASE (partially released) and RUN.
//     Domains never release out of order.
//   rst asserted mid-sequence returns all outputs to reset values immediately (async),
//     including relock_count and timeout_flag.
// TESTING
//   Bench parameters: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
//     LOCK_TIMEOUT_CYCLES=20, RELEASE_STAGGER=3, CNT_W=2.
//   1 Nominal bring-up: deassert rst, raise lock_raw at cycle 10 ->
//     - pll_rst high for cycles 1-4.
//     - domain_rst[0] falls 2+8 cycles after lock_raw rises.
//     - domain_rst[1] falls +3 cycles later, domain_rst[2] falls +6 cycles later.
//     - all_ready rises one cycle after domain_rst[2] falls.
//   2 Never lock -> timeout_flag set after 20 WAIT_LOCK cycles; pll_rst re-pulses for 4 cycles;
//     flag stays 1 through a later successful bring-up.
//   3 Glitch: lock_raw low for 1 cycle midway through STABLE -> no domain release;
//     the stable count restarts; relock_count stays 0.
//   4 Lock loss in RUN, repeated 4 times ->
//     - each loss: all domain_rst=1 and all_ready=0 one cycle after lock_s falls.
//     - relock_count reads 1, 2, 3, 3 (saturates).
//   5 sw_reset_req coincident with lock loss in RUN -> PLL_RESET entered, relock_count unchanged;
//     a second sw_reset_req during PLL_RESET does not extend the 4-cycle pll_rst pulse.
//   6 rst asserted mid-RELEASE with domain_rst=3'b110 ->
//     - outputs immediately read domain_rst=3'b111, pll_rst=1, counters 0.
//     - after rst drops, the sequence restarts from PLL_RESET.

Source files
------------

// File: rtl/pll_reset_supervisor.sv
// rtl/pll_reset_supervisor.sv - PLL lock supervisor and staggered domain reset sequencer
//
// Drives the PLL reset, qualifies the synchronised lock, then releases the
// downstream domain resets one after another (bit 0 first). Lock loss drops
// every domain back into reset and is counted; a lock timeout retries the PLL.
//
// Ports
//   clk_50_in     in   50 MHz reference clock
//   rst           in   asynchronous active-high reset
//   pll_lock_raw  in   PLL lock, asynchronous to clk_50_in
//   sw_reset_req  in   single-cycle request for a full PLL re-initialisation
//   pll_rst       out  reset to the PLL primitive, active-high
//   domain_rst    out  per-domain reset, active-high, bit 0 released first
//   all_ready     out  high only while every domain is released
//   relock_count  out  saturating count of lock-loss events after release
//   timeout_flag  out  sticky lock-timeout indicator, cleared only by rst

module pll_reset_supervisor #(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int RELEASE_STAGGER     = 16,
  parameter int CNT_W               = 8
) (
  input  logic                   clk_50_in,
  input  logic                   rst,
  input  logic                   pll_lock_raw,
  input  logic                   sw_reset_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic                   timeout_flag
);

  // The RELEASE state has to count up to the release point of the last domain.
  localparam int REL_SPAN = (NUM_DOMAINS - 1) * RELEASE_STAGGER;
  localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                            PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD   = (LOCK_TIMEOUT_CYCLES > REL_SPAN) ?
                            LOCK_TIMEOUT_CYCLES : REL_SPAN;
  localparam int MAX_CNT  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W    = $clog2(MAX_CNT + 1);

  localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELEASE_LAST = TMR_W'(REL_SPAN);
  localparam logic [CNT_W-1:0] RELOCK_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       cnt_q, cnt_d;
  logic                   lock_meta_q, lock_s_q;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   all_ready_q, all_ready_d;
  logic [CNT_W-1:0]       relock_q, relock_d;
  logic                   timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;

    case (state_q)
      // A software request here is ignored so the pulse is never stretched.
      PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      // Lock is tested before the timeout, so a lock on the last cycle wins.
      WAIT_LOCK: begin
        if (sw_reset_req) begin
          state_d = PLL_RESET;
        end else if (lock_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = PLL_RESET;
        end
      end
      STABLE: begin
        if (sw_reset_req) begin
          state_d = PLL_RESET;
        end else if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
        end
      end
      // Software request outranks a simultaneous lock loss and is not counted.
      RELEASE: begin
        if (sw_reset_req) begin
          state_d = PLL_RESET;
        end else if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (relock_q != RELOCK_MAX) relock_d = relock_q + CNT_W'(1);
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sw_reset_req) begin
          state_d = PLL_RESET;
        end else if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (relock_q != RELOCK_MAX) relock_d = relock_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PLL_RESET;
      end
    endcase

    // One shared timer: zero on every state entry, idle in RUN. Each state
    // leaves before the timer can pass its own terminal value.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != RUN) begin
      cnt_d = cnt_q + TMR_W'(1);
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    pll_rst_d   = (state_d == PLL_RESET);
    all_ready_d = (state_d == RUN);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (state_d == RUN) begin
        domain_rst_d[i] = 1'b0;
      end else if (state_d == RELEASE) begin
        // Domain i leaves reset i*RELEASE_STAGGER cycles into RELEASE, which
        // also guarantees in-order release.
        domain_rst_d[i] = (int'(cnt_d) < i * RELEASE_STAGGER);
      end else begin
        domain_rst_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50_in or posedge rst) begin
    if (rst) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= {NUM_DOMAINS{1'b1}};
      all_ready_q  <= 1'b0;
      relock_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      lock_meta_q  <= pll_lock_raw;
      lock_s_q     <= lock_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      all_ready_q  <= all_ready_d;
      relock_q     <= relock_d;
      timeout_q    <= timeout_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst   = domain_rst_q;
  assign all_ready    = all_ready_q;
  assign relock_count = relock_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// tb/tb_pll_reset_supervisor.sv - directed vector bench for pll_reset_supervisor

module tb_pll_reset_supervisor;

  logic       clk_50_in    = 1'b0;
  logic       rst          = 1'b1;
  logic       pll_lock_raw = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       all_ready;
  logic [1:0] relock_count;
  logic       timeout_flag;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int         n;
    logic       lock;
    logic       sw;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic [1:0] rc;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_50_in = ~clk_50_in;

  pll_reset_supervisor #(
    .NUM_DOMAINS         (3),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (20),
    .RELEASE_STAGGER     (3),
    .CNT_W               (2)
  ) dut (
    .clk_50_in    (clk_50_in),
    .rst          (rst),
    .pll_lock_raw (pll_lock_raw),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .all_ready    (all_ready),
    .relock_count (relock_count),
    .timeout_flag (timeout_flag)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50_in);
    #1;
  endtask

  task automatic check(input string name, input logic e_pll, input logic [2:0] e_dom,
                       input logic e_rdy, input logic [1:0] e_rc, input logic e_to);
    tests_run++;
    if (pll_rst !== e_pll) begin
      tests_failed++;
      $display("FAIL %s pll_rst got %b expected %b", name, pll_rst, e_pll);
    end
    tests_run++;
    if (domain_rst !== e_dom) begin
      tests_failed++;
      $display("FAIL %s domain_rst got %b expected %b", name, domain_rst, e_dom);
    end
    tests_run++;
    if (all_ready !== e_rdy) begin
      tests_failed++;
      $display("FAIL %s all_ready got %b expected %b", name, all_ready, e_rdy);
    end
    tests_run++;
    if (relock_count !== e_rc) begin
      tests_failed++;
      $display("FAIL %s relock_count got %0d expected %0d", name, relock_count, e_rc);
    end
    tests_run++;
    if (timeout_flag !== e_to) begin
      tests_failed++;
      $display("FAIL %s timeout_flag got %b expected %b", name, timeout_flag, e_to);
    end
  endtask

  task automatic add(input int n, input logic lock, input logic sw, input logic pll,
                     input logic [2:0] dom, input logic rdy, input logic [1:0] rc,
                     input logic to);
    vec_t v;
    v.n = n; v.lock = lock; v.sw = sw; v.pll = pll;
    v.dom = dom; v.rdy = rdy; v.rc = rc; v.to = to;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] rc_prev;
    logic [1:0] rc_new;

    // Nominal bring-up; edge numbers counted from rst release.
    add(3,  1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0); // edge 3
    add(1,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0); // edge 4
    add(5,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0); // edge 9
    add(10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0); // edge 19
    add(1,  1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd0, 1'b0); // edge 20
    add(2,  1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd0, 1'b0); // edge 22
    add(1,  1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 1'b0); // edge 23
    add(2,  1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 1'b0); // edge 25
    add(1,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0); // edge 26
    add(1,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0); // edge 27
    add(5,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0); // edge 32
    // Four lock losses in RUN, each followed by a full relock.
    for (int r = 1; r <= 4; r++) begin
      rc_prev = 2'(r - 1);
      rc_new  = (r > 3) ? 2'd3 : 2'(r);
      add(2,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, rc_prev, 1'b0);
      add(1,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, rc_new,  1'b0);
      add(10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, rc_new,  1'b0);
      add(1,  1'b1, 1'b0, 1'b0, 3'b110, 1'b0, rc_new,  1'b0);
      add(7,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, rc_new,  1'b0);
    end

    tick(3);
    check("reset_state", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      pll_lock_raw = vecs[k].lock;
      sw_reset_req = vecs[k].sw;
      tick(vecs[k].n);
      check($sformatf("vec%0d", k), vecs[k].pll, vecs[k].dom, vecs[k].rdy,
            vecs[k].rc, vecs[k].to);
    end

    // Async reset mid-RELEASE clears everything, including the saturated count.
    pll_lock_raw = 1'b0;
    tick(3);
    check("b_loss", 1'b0, 3'b111, 1'b0, 2'd3, 1'b0);
    pll_lock_raw = 1'b1;
    tick(11);
    check("b_release", 1'b0, 3'b110, 1'b0, 2'd3, 1'b0);
    #3 rst = 1'b1;
    #1 check("b_async_rst", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(2);
    check("b_rst_hold", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(3);
    check("b_pll_e3", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    check("b_pll_e4", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(8);
    check("b_stable_e12", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    check("b_release_e13", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0);
    tick(7);
    check("b_run_e20", 1'b0, 3'b000, 1'b1, 2'd0, 1'b0);

    // sw_reset_req coincident with lock loss, then a second request in PLL_RESET.
    tick(2);
    pll_lock_raw = 1'b0;
    tick(2);
    check("c_pre_sw", 1'b0, 3'b000, 1'b1, 2'd0, 1'b0);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check("c_sw_entry", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(1);
    check("c_pll_last", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    check("c_pll_end", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);

    // One-cycle lock glitch midway through STABLE restarts the stable count.
    pll_lock_raw = 1'b1;
    tick(5);
    pll_lock_raw = 1'b0;
    tick(1);
    pll_lock_raw = 1'b1;
    tick(5);
    check("g_no_release", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(5);
    check("g_before_rel", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    check("g_release", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0);
    tick(7);
    check("g_run", 1'b0, 3'b000, 1'b1, 2'd0, 1'b0);

    // Never lock: timeout, PLL retry, then a good bring-up keeps the flag.
    rst = 1'b1;
    pll_lock_raw = 1'b0;
    tick(2);
    check("t_rst", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(23);
    check("t_before_to", 1'b0, 3'b111, 1'b0, 2'd0, 1'b0);
    tick(1);
    check("t_timeout", 1'b1, 3'b111, 1'b0, 2'd0, 1'b1);
    tick(3);
    check("t_repulse_last", 1'b1, 3'b111, 1'b0, 2'd0, 1'b1);
    tick(1);
    check("t_repulse_end", 1'b0, 3'b111, 1'b0, 2'd0, 1'b1);
    pll_lock_raw = 1'b1;
    tick(11);
    check("t_release", 1'b0, 3'b110, 1'b0, 2'd0, 1'b1);
    tick(7);
    check("t_run", 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
